// File: rtl/instruction_decode_pipe_pkg.sv
// Shared encodings for the instruction decode pipe: opcodes, operand selects,
// operation selects, write-enable bit positions and the stored decoded entry.
package instruction_decode_pipe_pkg;

    localparam logic [2:0] OPC_ADV = 3'd0;
    localparam logic [2:0] OPC_BXL = 3'd1;
    localparam logic [2:0] OPC_BST = 3'd2;
    localparam logic [2:0] OPC_JNZ = 3'd3;
    localparam logic [2:0] OPC_BXC = 3'd4;
    localparam logic [2:0] OPC_OUT = 3'd5;
    localparam logic [2:0] OPC_BDV = 3'd6;
    localparam logic [2:0] OPC_CDV = 3'd7;

    typedef enum logic [1:0] {
        SEL_REG_A   = 2'd0,
        SEL_REG_B   = 2'd1,
        SEL_REG_C   = 2'd2,
        SEL_LITERAL = 2'd3
    } op_sel_e;

    typedef enum logic [1:0] {
        OPS_SHIFT = 2'd0,
        OPS_XOR   = 2'd1,
        OPS_MOD8  = 2'd2,
        OPS_JUMP  = 2'd3
    } operation_e;

    localparam int WR_A   = 0;
    localparam int WR_B   = 1;
    localparam int WR_C   = 2;
    localparam int WR_OUT = 3;

    typedef struct packed {
        op_sel_e    op1;
        op_sel_e    op2;
        operation_e operation;
        logic [3:0] wr_en;
        logic       illegal;
        logic [2:0] operand;
    } decoded_t;

    localparam int DEC_W = $bits(decoded_t);

    // Operand 7 maps to LITERAL; the caller flags it as illegal.
    function automatic op_sel_e combo_sel(input logic [2:0] operand);
        case (operand)
            3'd4:    combo_sel = SEL_REG_A;
            3'd5:    combo_sel = SEL_REG_B;
            3'd6:    combo_sel = SEL_REG_C;
            default: combo_sel = SEL_LITERAL;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decode_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode pipe.
interface instruction_decode_pipe_if #(
    parameter int DATA_W = 48,
    parameter int PC_W   = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_opcode;
    logic [2:0]        in_operand;
    logic [PC_W-1:0]   in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_literal;
    logic [1:0]        op1_sel;
    logic [1:0]        op2_sel;
    logic [1:0]        operation_sel;
    logic [3:0]        reg_wr_en;
    logic              illegal;

    modport master (
        output in_valid, in_opcode, in_operand, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_literal,
        input  op1_sel, op2_sel, operation_sel, reg_wr_en, illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_operand, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_literal,
        output op1_sel, op2_sel, operation_sel, reg_wr_en, illegal
    );
endinterface

// File: rtl/instruction_decode_pipe_comb.sv
// Purely combinational opcode/operand decode, including combo-operand
// resolution and illegal-operand detection.
module instruction_decode_comb
    import instruction_decode_pipe_pkg::*;
(
    input  logic [2:0] opcode_i,
    input  logic [2:0] operand_i,
    output op_sel_e    op1_sel_o,
    output op_sel_e    op2_sel_o,
    output operation_e operation_sel_o,
    output logic [3:0] reg_wr_en_o,
    output logic       illegal_o
);

    logic    uses_combo;
    op_sel_e combo;

    assign combo = combo_sel(operand_i);

    always_comb begin
        op1_sel_o       = SEL_REG_A;
        op2_sel_o       = SEL_REG_A;
        operation_sel_o = OPS_SHIFT;
        reg_wr_en_o     = '0;
        uses_combo      = 1'b0;
        case (opcode_i)
            OPC_ADV: begin
                op2_sel_o          = combo;
                reg_wr_en_o[WR_A]  = 1'b1;
                uses_combo         = 1'b1;
            end
            OPC_BXL: begin
                op1_sel_o          = SEL_REG_B;
                op2_sel_o          = SEL_LITERAL;
                operation_sel_o    = OPS_XOR;
                reg_wr_en_o[WR_B]  = 1'b1;
            end
            OPC_BST: begin
                op1_sel_o          = combo;
                operation_sel_o    = OPS_MOD8;
                reg_wr_en_o[WR_B]  = 1'b1;
                uses_combo         = 1'b1;
            end
            OPC_JNZ: begin
                op2_sel_o          = SEL_LITERAL;
                operation_sel_o    = OPS_JUMP;
            end
            OPC_BXC: begin
                op1_sel_o          = SEL_REG_B;
                op2_sel_o          = SEL_REG_C;
                operation_sel_o    = OPS_XOR;
                reg_wr_en_o[WR_B]  = 1'b1;
            end
            OPC_OUT: begin
                op1_sel_o          = combo;
                operation_sel_o    = OPS_MOD8;
                reg_wr_en_o[WR_OUT] = 1'b1;
                uses_combo         = 1'b1;
            end
            OPC_BDV: begin
                op2_sel_o          = combo;
                reg_wr_en_o[WR_B]  = 1'b1;
                uses_combo         = 1'b1;
            end
            OPC_CDV: begin
                op2_sel_o          = combo;
                reg_wr_en_o[WR_C]  = 1'b1;
                uses_combo         = 1'b1;
            end
            default: begin
                uses_combo         = 1'b0;
            end
        endcase
    end

    // Only opcodes that actually read a combo operand can be illegal.
    assign illegal_o = uses_combo && (operand_i == 3'd7);

endmodule

// File: rtl/instruction_decode_pipe.sv
// Decode stage: decodes each accepted instruction and queues the decoded
// fields in a small flop FIFO whose head drives the execute-side outputs.
module instruction_decode_pipe
    import instruction_decode_pipe_pkg::*;
#(
    parameter int DATA_W = 48,
    parameter int PC_W   = 8,
    parameter int DEPTH  = 2
) (
    input logic clk,
    input logic rst_n,
    input logic halt,
    input logic flush,
    instruction_decode_pipe_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             jnz_blk_q, jnz_blk_d;

    logic [DEC_W-1:0] dec_mem_q [DEPTH];
    logic [PC_W-1:0]  pc_mem_q  [DEPTH];
    decoded_t         hold_dec_q;
    logic [PC_W-1:0]  hold_pc_q;

    decoded_t         push_dec;
    decoded_t         head_dec;
    logic [PC_W-1:0]  head_pc;
    decoded_t         out_dec;
    logic [PC_W-1:0]  out_pc;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;
    logic             not_empty;

    instruction_decode_comb u_decode (
        .opcode_i        (bus.in_opcode),
        .operand_i       (bus.in_operand),
        .op1_sel_o       (push_dec.op1),
        .op2_sel_o       (push_dec.op2),
        .operation_sel_o (push_dec.operation),
        .reg_wr_en_o     (push_dec.wr_en),
        .illegal_o       (push_dec.illegal)
    );
    assign push_dec.operand = bus.in_operand;

    assign not_empty = (count_q != '0);
    assign in_ready  = rst_n && !halt && !flush && !jnz_blk_q
                       && (count_q < CNT_W'(DEPTH));
    assign out_valid = not_empty && !halt;
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    assign head_dec  = decoded_t'(dec_mem_q[rd_ptr_q]);
    assign head_pc   = pc_mem_q[rd_ptr_q];

    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        jnz_blk_d = jnz_blk_q;
        if (flush) begin
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            jnz_blk_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // Only one JNZ can be in flight, so popping any JNZ releases the block.
            if (pop && (head_dec.operation == OPS_JUMP)) begin
                jnz_blk_d = 1'b0;
            end
            if (push && (push_dec.operation == OPS_JUMP)) begin
                jnz_blk_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            jnz_blk_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            jnz_blk_q <= jnz_blk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dec_mem_q[wr_ptr_q] <= DEC_W'(push_dec);
            pc_mem_q[wr_ptr_q]  <= bus.in_pc;
        end
    end

    // Tracks the head so the outputs keep the last head value once empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_dec_q <= '0;
            hold_pc_q  <= '0;
        end else if (not_empty) begin
            hold_dec_q <= head_dec;
            hold_pc_q  <= head_pc;
        end
    end

    assign out_dec = not_empty ? head_dec : hold_dec_q;
    assign out_pc  = not_empty ? head_pc  : hold_pc_q;

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_pc        = out_pc;
    assign bus.out_literal   = DATA_W'(out_dec.operand);
    assign bus.op1_sel       = out_dec.op1;
    assign bus.op2_sel       = out_dec.op2;
    assign bus.operation_sel = out_dec.operation;
    assign bus.reg_wr_en     = out_dec.wr_en;
    assign bus.illegal       = out_dec.illegal;

endmodule

// File: tb/tb_instruction_decode_pipe.sv
// Scoreboard bench for instruction_decode_pipe: directed scenarios followed by
// randomized traffic, checked against a table-driven queue model.
module tb_instruction_decode_pipe;

    localparam int DATA_W = 48;
    localparam int PC_W   = 8;
    localparam int DEPTH  = 2;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] lit;
        logic [1:0]        op1;
        logic [1:0]        op2;
        logic [1:0]        oper;
        logic [3:0]        wr;
        logic              ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic halt;
    logic flush;

    instruction_decode_pipe_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

    instruction_decode_pipe #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .halt  (halt),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb [$];
    bit   blocked     = 1'b0;
    bit   en          = 1'b0;
    exp_t last_shown  = '0;

    // Decode table by opcode ADV..CDV; -1 in a select column means combo operand.
    int op1_t  [8] = '{0, 1, -1, 0, 1, -1, 0, 0};
    int op2_t  [8] = '{-1, 3, 0, 3, 2, 0, -1, -1};
    int oper_t [8] = '{0, 1, 2, 3, 1, 2, 0, 0};
    int wr_t   [8] = '{0, 1, 1, -1, 1, 3, 1, 2};

    function automatic exp_t ref_decode(input logic [2:0] opc, input logic [2:0] opr,
                                        input logic [PC_W-1:0] pc);
        exp_t e;
        int   combo;
        int   o1;
        int   o2;
        int   w;
        combo = (opr >= 3'd4 && opr <= 3'd6) ? int'(opr) - 4 : 3;
        o1 = op1_t[opc];
        o2 = op2_t[opc];
        w  = wr_t[opc];
        e.pc   = pc;
        e.lit  = DATA_W'(opr);
        e.op1  = 2'((o1 < 0) ? combo : o1);
        e.op2  = 2'((o2 < 0) ? combo : o2);
        e.oper = 2'(oper_t[opc]);
        e.wr   = (w < 0) ? 4'b0000 : 4'(1 << w);
        e.ill  = ((o1 < 0) || (o2 < 0)) && (opr == 3'd7);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_fields(input string nm, input exp_t e);
        chk({nm, ".pc"},      64'(bus.out_pc),        64'(e.pc));
        chk({nm, ".literal"}, 64'(bus.out_literal),   64'(e.lit));
        chk({nm, ".op1"},     64'(bus.op1_sel),       64'(e.op1));
        chk({nm, ".op2"},     64'(bus.op2_sel),       64'(e.op2));
        chk({nm, ".oper"},    64'(bus.operation_sel), 64'(e.oper));
        chk({nm, ".wr"},      64'(bus.reg_wr_en),     64'(e.wr));
        chk({nm, ".illegal"}, 64'(bus.illegal),       64'(e.ill));
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        cmp_fields(nm, exp_t'('0));
    endtask

    // Monitor and scoreboard: compare against the model state, then advance it
    // with the inputs that the coming rising edge will see.
    always @(negedge clk) begin
        bit   exp_ir;
        bit   exp_ov;
        exp_t item;
        exp_ir = rst_n && !halt && !flush && !blocked && (sb.size() < DEPTH);
        exp_ov = (sb.size() > 0) && !halt;
        if (en) begin
            chk("in_ready",  64'(bus.in_ready),  64'(exp_ir));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            if (sb.size() > 0) begin
                if (bus.out_valid) cmp_fields("head", sb[0]);
            end else if (rst_n) begin
                cmp_fields("hold", last_shown);
            end
        end
        if (sb.size() > 0) last_shown = sb[0];
        if (!rst_n) begin
            sb.delete();
            blocked    = 1'b0;
            last_shown = '0;
        end else if (flush) begin
            sb.delete();
            blocked = 1'b0;
        end else begin
            if (exp_ov && bus.out_ready) begin
                if (sb[0].oper == 2'd3) blocked = 1'b0;
                void'(sb.pop_front());
            end
            if (bus.in_valid && exp_ir) begin
                item = ref_decode(bus.in_opcode, bus.in_operand, bus.in_pc);
                sb.push_back(item);
                if (item.oper == 2'd3) blocked = 1'b1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] opc, input logic [2:0] opr, input logic [PC_W-1:0] pc);
        bit acc;
        acc = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_opcode  = opc;
        bus.in_operand = opr;
        bus.in_pc      = pc;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: pc %0h not accepted within 60 cycles", pc);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic release_after(input int n);
        repeat (n) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        halt           = 1'b0;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_opcode  = '0;
        bus.in_operand = '0;
        bus.in_pc      = '0;
        bus.out_ready  = 1'b0;
        repeat (2) cyc();
        en = 1'b1;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outs("post_reset");
        cyc();

        // Single BXL, then ADV/BST/OUT back to back with execute always ready.
        bus.out_ready = 1'b1;
        send(3'd1, 3'd5, 8'd3);
        repeat (2) cyc();
        send(3'd0, 3'd6, 8'h10);
        send(3'd2, 3'd4, 8'h11);
        send(3'd5, 3'd7, 8'h12);
        repeat (3) cyc();

        // Fill with execute stalled; third push waits for a pop.
        bus.out_ready = 1'b0;
        send(3'd4, 3'd1, 8'h20);
        send(3'd6, 3'd5, 8'h21);
        fork
            send(3'd7, 3'd2, 8'h22);
            release_after(3);
        join
        repeat (4) cyc();

        // JNZ blocks further pushes until it leaves the buffer.
        bus.out_ready = 1'b0;
        send(3'd3, 3'd0, 8'h30);
        fork
            send(3'd1, 3'd2, 8'h31);
            release_after(3);
        join
        repeat (3) cyc();

        // Flush a full buffer while a new instruction is offered.
        bus.out_ready = 1'b0;
        send(3'd0, 3'd3, 8'h40);
        send(3'd2, 3'd6, 8'h41);
        bus.in_valid   = 1'b1;
        bus.in_opcode  = 3'd1;
        bus.in_operand = 3'd1;
        bus.in_pc      = 8'h42;
        flush          = 1'b1;
        cyc();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush.out_valid", 64'(bus.out_valid), 64'd0);
        cyc();

        // Halt with a full buffer and a ready consumer, then release.
        send(3'd5, 3'd4, 8'h50);
        send(3'd7, 3'd6, 8'h51);
        halt          = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        halt = 1'b0;
        repeat (3) cyc();

        // Reset in the middle of a stream.
        bus.out_ready = 1'b0;
        send(3'd6, 3'd1, 8'h60);
        send(3'd4, 3'd5, 8'h61);
        rst_n = 1'b0;
        cyc();
        @(negedge clk);
        chk_reset_outs("mid_reset");
        cyc();
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 800; i++) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.in_opcode  = 3'($urandom_range(0, 7));
            bus.in_operand = 3'($urandom_range(0, 7));
            bus.in_pc      = 8'($urandom_range(0, 255));
            bus.out_ready  = ($urandom_range(0, 9) < 7);
            halt           = ($urandom_range(0, 9) == 0);
            flush          = ($urandom_range(0, 19) == 0);
            rst_n          = ($urandom_range(0, 99) != 0);
            cyc();
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        halt          = 1'b0;
        flush         = 1'b0;
        rst_n         = 1'b1;
        repeat (6) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_decode_pipe.md
INSTRUCTION_DECODE_PIPE -- requirements
Module: instruction_decode_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 48, meaning datapath/literal-extension width for decoded literal operand.
REQ-002 SHALL have parameter PC_W, default 8, meaning program-counter width carried with each instruction.
REQ-003 SHALL have parameter DEPTH, default 2, meaning decoded-entry buffer depth (power of two, >=2).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 halt  in  1  freezes buffer state; no push, no pop while high.
REQ-007 flush  in  1  taken-jump kill from execute; discards all buffered and incoming entries.
REQ-008 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-009 in_opcode, in_operand  in  3, 3  raw instruction fields.
REQ-010 in_pc  in  PC_W  address of instruction.
REQ-011 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-012 out_pc  out  PC_W; out_literal  out  DATA_W  operand zero-extended.
REQ-013 op1_sel, op2_sel  out  2, 2  0=REG_A 1=REG_B 2=REG_C 3=LITERAL.
REQ-014 operation_sel  out  2  0=SHIFT 1=XOR 2=MOD8 3=JUMP.
REQ-015 reg_wr_en  out  4  one-hot: bit0 A, bit1 B, bit2 C, bit3 OUT; all-zero for JNZ.
REQ-016 illegal  out  1  head entry uses combo operand 7.

Function
REQ-017 Decode table (op1/op2/operation/wr): ADV A/combo/SHIFT/A; BXL B/LIT/XOR/B; BST combo/-/MOD8/B; JNZ A/LIT/JUMP/none; BXC B/C/XOR/B; OUT combo/-/MOD8/OUT; BDV A/combo/SHIFT/B; CDV A/combo/SHIFT/C.
REQ-018 Combo resolution SHALL be done in decode: operand 0-3 -> LITERAL, 4 -> REG_A, 5 -> REG_B, 6 -> REG_C, 7 -> sel LITERAL and illegal=1.
REQ-019 Unused select fields ("-") SHALL be driven 0, not retained.
REQ-020 Decode SHALL be combinational on push; decoded fields stored in buffer; outputs driven from head entry (registered, 1-cycle latency from accepted push to out_valid when empty).
REQ-021 in_ready SHALL be 1 iff count<DEPTH and halt=0 and flush=0.
REQ-022 Push on in_valid&&in_ready; pop on out_valid&&out_ready&&!halt; simultaneous push and pop when full SHALL NOT be allowed (in_ready low), when nonempty SHALL keep count unchanged.
REQ-023 out_valid SHALL be 1 iff count>0 and halt=0.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-025 flush SHALL, on that edge, set count, pointers to 0 and drop any same-cycle push; flush has priority over halt.
REQ-026 After JNZ entry is pushed, further pushes SHALL be blocked (in_ready=0) until that JNZ is popped or flush asserted.
REQ-027 Outputs while out_valid=0 SHALL hold last head value; consumers SHALL qualify with out_valid.

Reset
REQ-028 While rst_n=0 at a rising edge: count, pointers, JNZ-block flag SHALL clear to 0.
REQ-029 Reset outputs: out_valid=0, in_ready=0 during reset then 1, reg_wr_en=0, illegal=0, all selects 0, out_pc=0, out_literal=0.
REQ-030 Reset mid-operation SHALL discard all entries with no pop reported.

Structure
REQ-031 Shared package SHALL hold opcode constants (ADV..CDV), op select encodings, operation_sel encodings, reg_wr_en bit positions, decoded-entry struct/width.
REQ-032 Combinational decode SHALL be one sub-module, instruction_decode_comb (opcode, operand -> fields, illegal).
REQ-033 Buffer SHALL be flop-based in this module; no memory macros.

Verification
REQ-034 Push BXL op=5 pc=3, out_ready=1 -> next cycle out_valid=1, op1=1, op2=3, op=1, wr=0010, literal=5, pc=3.
REQ-035 Push ADV op=6, BST op=4, OUT op=7 -> op2=2/wr=0001; op1=0/wr=0010; illegal=1/wr=1000.
REQ-036 out_ready=0, push 3 instructions -> count saturates at DEPTH=2, in_ready=0 on 3rd, 3rd accepted only after one pop; order preserved.
REQ-037 Push JNZ op=0 then hold in_valid -> in_ready=0 until JNZ popped; wr=0000, op=3.
REQ-038 Buffer full, assert flush with in_valid -> next cycle out_valid=0, count=0, no entry accepted.
REQ-039 halt=1 with full buffer and out_ready=1 -> no pops, out_valid=0; deassert halt -> entries emerge in original order; rst_n=0 mid-stream -> all outputs at reset values next edge.
